// File: rtl/alu_multicycle.sv
// Multi-cycle RV32I execute unit: single-cycle ALU/compare/CSR functions,
// serial one-bit-per-cycle shifts, valid/ready handshakes on both sides.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       alu_ctl,
  input  logic             unsigned_cmp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_enable
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       op_r;
  logic [2:0]       cond_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] shreg_r;
  logic [4:0]       cnt_r;
  logic             start_shift;
  logic [WIDTH-1:0] shifted;

  // Shift codes fall back to operand A here; this path only serves shamt 0.
  function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0] op, input logic ucmp,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    logic             lt;
    lt = ucmp ? (x < y) : ($signed(x) < $signed(y));
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0011: r = x;
      4'b0100: r = x;
      4'b0101: r = x;
      4'b0110: r = x - y;
      4'b0111: r = {{(WIDTH-1){1'b0}}, lt};
      4'b1000: r = x ^ y;
      4'b1001: r = x;
      4'b1010: r = x | y;
      4'b1011: r = ~x & y;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic branch_calc(input logic [2:0] cond, input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y);
    logic t;
    case (cond)
      3'b001:  t = (x == y);
      3'b010:  t = (x != y);
      3'b011:  t = ($signed(x) < $signed(y));
      3'b100:  t = ($signed(x) >= $signed(y));
      3'b101:  t = (x < y);
      3'b110:  t = (x >= y);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (op)
      4'b0011: r = {1'b0, v[WIDTH-1:1]};
      4'b0100: r = {v[WIDTH-1], v[WIDTH-1:1]};
      4'b0101: r = {v[WIDTH-2:0], 1'b0};
      default: r = v;
    endcase
    return r;
  endfunction

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign start_shift = ((alu_ctl[3:0] == 4'b0011) || (alu_ctl[3:0] == 4'b0100) ||
                        (alu_ctl[3:0] == 4'b0101)) && (b[4:0] != 5'd0);
  assign shifted     = shift_one(op_r, shreg_r);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = start_shift ? SHIFT : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == 5'd1) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, serial shifter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r          <= 4'd0;
      cond_r        <= 3'd0;
      a_r           <= '0;
      b_r           <= '0;
      shreg_r       <= '0;
      cnt_r         <= 5'd0;
      result        <= '0;
      branch_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r   <= alu_ctl[3:0];
            cond_r <= alu_ctl[6:4];
            a_r    <= a;
            b_r    <= b;
            if (start_shift) begin
              shreg_r <= a;
              cnt_r   <= b[4:0];
            end else begin
              result        <= alu_calc(alu_ctl[3:0], unsigned_cmp, a, b);
              branch_enable <= branch_calc(alu_ctl[6:4], a, b);
            end
          end
        end
        SHIFT: begin
          shreg_r <= shifted;
          cnt_r   <= cnt_r - 5'd1;
          // Final step: publish this cycle's shifted value directly.
          if (cnt_r == 5'd1) begin
            result        <= shifted;
            branch_enable <= branch_calc(cond_r, a_r, b_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases, randomized ops against
// a behavioural model, backpressure and mid-shift reset.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  alu_ctl;
  logic        unsigned_cmp;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_enable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .unsigned_cmp(unsigned_cmp), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_enable(branch_enable)
  );

  function automatic logic [31:0] model_result(input logic [6:0] ctl, input logic ucmp,
                                               input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    int sh;
    sx = x;
    sh = int'(y[4:0]);
    case (ctl[3:0])
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x >> sh;
      4'd4:  return sx >>> sh;
      4'd5:  return x << sh;
      4'd6:  return x - y;
      4'd7:  return (ucmp ? (x < y) : ($signed(x) < $signed(y))) ? 32'd1 : 32'd0;
      4'd8:  return x ^ y;
      4'd9:  return x;
      4'd10: return x | y;
      4'd11: return ~x & y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_branch(input logic [6:0] ctl, input logic [31:0] x,
                                        input logic [31:0] y);
    case (ctl[6:4])
      3'd1: return x == y;
      3'd2: return x != y;
      3'd3: return $signed(x) < $signed(y);
      3'd4: return $signed(x) >= $signed(y);
      3'd5: return x < y;
      3'd6: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_latency(input logic [6:0] ctl, input logic [31:0] y);
    if ((ctl[3:0] >= 4'd3) && (ctl[3:0] <= 4'd5) && (y[4:0] != 5'd0))
      return 1 + int'(y[4:0]);
    return 1;
  endfunction

  // One full transaction; expects to start and end #1 after a rising edge.
  task automatic do_op(input string name, input logic [6:0] ctl, input logic ucmp,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic eb);
    int guard;
    int lat;
    int elat;
    elat = model_latency(ctl, y);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    alu_ctl = ctl; unsigned_cmp = ucmp; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (result !== er) begin
      errors++; $display("FAIL %s result: got %h want %h", name, result, er);
    end
    checks++;
    if (branch_enable !== eb) begin
      errors++; $display("FAIL %s branch: got %b want %b", name, branch_enable, eb);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctl = 7'd0; unsigned_cmp = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || branch_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset: got ov=%b ir=%b res=%h br=%b want 0 1 0 0",
               out_valid, in_ready, result, branch_enable);
    end
  endtask

  task automatic test_directed();
    do_op("add",      7'b0000010, 1'b0, 32'h5,        32'h3,        32'h8,        1'b0);
    do_op("beq",      7'b0010110, 1'b0, 32'h1234,     32'h1234,     32'h0,        1'b1);
    do_op("blt_eq",   7'b0110110, 1'b0, 32'h1234,     32'h1234,     32'h0,        1'b0);
    do_op("bge",      7'b1000110, 1'b0, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0);
    do_op("bgeu",     7'b1100110, 1'b0, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b1);
    do_op("sra31",    7'b0000100, 1'b0, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0);
    do_op("srl4",     7'b0000011, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1'b0);
    do_op("sll0",     7'b0000101, 1'b0, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0);
    do_op("slt",      7'b0000111, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0);
    do_op("sltu",     7'b0000111, 1'b1, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0);
    do_op("csrrc",    7'b0001011, 1'b0, 32'h0F,       32'hFF,       32'hF0,       1'b0);
    do_op("op1111",   7'b1011111, 1'b0, 32'h1,        32'h2,        32'h0,        1'b1);
  endtask

  task automatic test_random();
    logic [6:0]  ctl;
    logic        ucmp;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 40; i++) begin
      ctl  = 7'($urandom);
      ucmp = 1'($urandom);
      x    = $urandom;
      y    = ($urandom_range(0, 3) == 0) ? x : $urandom;
      do_op("random", ctl, ucmp, x, y, model_result(ctl, ucmp, x, y), model_branch(ctl, x, y));
    end
  endtask

  task automatic test_backpressure();
    alu_ctl = 7'b0000010; unsigned_cmp = 1'b0; a = 32'h11; b = 32'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_ctl = 7'b0001000; a = 32'hF0; b = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h33) begin
        errors++;
        $display("FAIL bp_hold: got ov=%b ir=%b res=%h want 1 0 00000033", out_valid, in_ready, result);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hFF) begin
      errors++; $display("FAIL bp_next: got ov=%b res=%h want 1 000000ff", out_valid, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    alu_ctl = 7'b0000101; unsigned_cmp = 1'b0; a = 32'h1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL shift_busy: got ov=%b ir=%b want 0 0", out_valid, in_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || branch_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b ir=%b res=%h br=%b want 0 1 0 0",
               out_valid, in_ready, result, branch_enable);
    end
    do_op("add_after_reset", 7'b0000010, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
